// File: rtl/operand_entry_pkg.sv
// Shared constants and helpers for the operand-entry editor: state encoding,
// button indices, default repeat timing and the single-nibble edit rule.
package operand_entry_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT_A = 2'd1,
      ST_EDIT_B = 2'd2
   } state_t;

   localparam int unsigned BTN_INC   = 0;
   localparam int unsigned BTN_DEC   = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;

   localparam int unsigned REPEAT_DLY_DEF = 25_000_000;
   localparam int unsigned REPEAT_PER_DEF = 5_000_000;
   localparam int unsigned CW_DEF         = 25;

   // Simultaneous inc and dec clear the nibble; otherwise wrap mod 16 with no carry out.
   function automatic logic [3:0] step_nibble(input logic [3:0] nib,
                                              input logic       inc,
                                              input logic       dec);
      logic [3:0] res;
      if (inc && dec) begin
         res = 4'd0;
      end else if (inc) begin
         res = nib + 4'd1;
      end else if (dec) begin
         res = nib - 4'd1;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/operand_entry_btn_repeat.sv
// Hold-to-repeat generator for one button: merges the debounced pulse with
// auto-repeat steps so that a coincident pulse and repeat count as one step.
module btn_repeat
   import operand_entry_pkg::*;
#(
   parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
   parameter int unsigned CW         = CW_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic level,
   input  logic pulse,
   output logic step
);

   logic [CW-1:0] cnt_r;
   logic          rep_r;
   logic          hit_s;

   // A repeat fires on the last cycle of the initial delay, then every period.
   always_comb begin
      hit_s = 1'b0;
      if (enable && level) begin
         if (rep_r) begin
            hit_s = (cnt_r == CW'(REPEAT_PER - 1));
         end else begin
            hit_s = (cnt_r == CW'(REPEAT_DLY - 1));
         end
      end else begin
         hit_s = 1'b0;
      end
   end

   assign step = enable && (pulse || hit_s);

   // Hold counter and repeating flag; released or disabled buttons start over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
         rep_r <= 1'b0;
      end else if (!enable || !level) begin
         cnt_r <= {CW{1'b0}};
         rep_r <= 1'b0;
      end else if (hit_s) begin
         cnt_r <= {CW{1'b0}};
         rep_r <= 1'b1;
      end else begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/operand_entry.sv
// Cursor-based hex-nibble editor producing the registered operands A and B,
// with hold-to-repeat on inc/dec and a one-hot blink mask for the display.
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
   parameter int unsigned CW         = CW_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  btn_pulse,
   input  logic [3:0]  btn_level,
   input  logic [4:0]  disp_sel,
   input  logic [1:0]  digit_grp,
   output logic [63:0] A,
   output logic [63:0] B,
   output logic [1:0]  state,
   output logic [1:0]  cursor,
   output logic [3:0]  blink
);

   state_t      state_r, next_st_s;
   logic [63:0] a_r, b_r, a_nx_s, b_nx_s;
   logic [1:0]  cursor_r, cur_nx_s;
   logic [3:0]  blink_r, blink_nx_s;
   logic        chg_s, edit_en_s, inc_s, dec_s;
   logic [5:0]  bit_base_s;
   logic        unused_lvl_s;

   assign unused_lvl_s = ^btn_level[3:2];

   // Next state follows disp_sel directly.
   always_comb begin
      next_st_s = ST_IDLE;
      case (disp_sel)
         5'd0:    next_st_s = ST_EDIT_A;
         5'd1:    next_st_s = ST_EDIT_B;
         default: next_st_s = ST_IDLE;
      endcase
   end

   // Edits are suppressed on the cycle the state changes, so switching operands never edits.
   assign chg_s      = (next_st_s != state_r);
   assign edit_en_s  = (state_r != ST_IDLE) && !chg_s;
   assign bit_base_s = {digit_grp, cursor_r, 2'b00};

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .CW(CW)) u_rep_inc (
      .clk    (clk),
      .rst    (rst),
      .enable (edit_en_s),
      .level  (btn_level[BTN_INC]),
      .pulse  (btn_pulse[BTN_INC]),
      .step   (inc_s)
   );

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .CW(CW)) u_rep_dec (
      .clk    (clk),
      .rst    (rst),
      .enable (edit_en_s),
      .level  (btn_level[BTN_DEC]),
      .pulse  (btn_pulse[BTN_DEC]),
      .step   (dec_s)
   );

   // Nibble read-modify-write and cursor update; the edit uses the pre-move cursor.
   always_comb begin
      a_nx_s   = a_r;
      b_nx_s   = b_r;
      cur_nx_s = cursor_r;
      if (chg_s) begin
         cur_nx_s = 2'd0;
      end else if (edit_en_s) begin
         if (state_r == ST_EDIT_A) begin
            a_nx_s[bit_base_s +: 4] = step_nibble(a_r[bit_base_s +: 4], inc_s, dec_s);
         end else begin
            b_nx_s[bit_base_s +: 4] = step_nibble(b_r[bit_base_s +: 4], inc_s, dec_s);
         end
         case ({btn_pulse[BTN_RIGHT], btn_pulse[BTN_LEFT]})
            2'b01:   cur_nx_s = cursor_r + 2'd1;
            2'b10:   cur_nx_s = cursor_r - 2'd1;
            default: cur_nx_s = cursor_r;
         endcase
      end else begin
         cur_nx_s = cursor_r;
      end
   end

   // Blink tracks the cursor only while editing.
   always_comb begin
      blink_nx_s = 4'b0000;
      if (next_st_s != ST_IDLE) begin
         blink_nx_s = 4'b0001 << cur_nx_s;
      end else begin
         blink_nx_s = 4'b0000;
      end
   end

   // Architectural registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         a_r      <= 64'd0;
         b_r      <= 64'd0;
         cursor_r <= 2'd0;
         blink_r  <= 4'b0000;
      end else begin
         state_r  <= next_st_s;
         a_r      <= a_nx_s;
         b_r      <= b_nx_s;
         cursor_r <= cur_nx_s;
         blink_r  <= blink_nx_s;
      end
   end

   assign A      = a_r;
   assign B      = b_r;
   assign state  = state_r;
   assign cursor = cursor_r;
   assign blink  = blink_r;

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream operand-entry stage of the calculator datapath. Turns debounced push-button pulses and levels into the two 64-bit operands A and B, which feed the integer, shift and logic units and the display mux.
- Edits one hex nibble at a time under a cursor. Supports hold-to-repeat and produces the per-digit blink mask for the 7-segment display.
- Replaces purely combinational operand capture with a registered, state-machine-controlled editor.

Parameters:
- REPEAT_DLY, 25_000_000, hold time in clk cycles before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_PER, 5_000_000, cycles between auto-repeat steps once repeating (0.1 s).
- CW, 25, width of the repeat counters; must hold max(REPEAT_DLY, REPEAT_PER).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- btn_pulse  in  4  single-cycle pulses from the debouncer. [0]=inc, [1]=dec, [2]=cursor left, [3]=cursor right.
- btn_level  in  4  debounced button levels; only [1:0] are used, for auto-repeat.
- disp_sel  in  5  display/edit selector: 0 = edit A, 1 = edit B, other values = locked.
- digit_grp  in  2  selects the 16-bit window (4 nibbles) in view: window base nibble = digit_grp*4.
- A  out  64  operand A (registered).
- B  out  64  operand B (registered).
- state  out  2  current state: 0 IDLE, 1 EDIT_A, 2 EDIT_B.
- cursor  out  2  cursor position within the window.
- blink  out  4  one-hot digit blink mask for the display.

Behaviour:
Reset (async, immediate):
- A=0, B=0, state=IDLE, cursor=0, blink=0.
- Repeat counters=0, repeating flags=0.

State machine (registered every cycle from disp_sel):
- disp_sel==0 -> EDIT_A; disp_sel==1 -> EDIT_B; any other value -> IDLE.
- On any state change:
  - cursor <= 0 and repeat counters cleared.
  - All button pulses in that same cycle are ignored (no operand or cursor update).

Edit target:
- Nibble index n = digit_grp*4 + cursor, range 0..15. Bits [4n+3:4n] of A (EDIT_A) or B (EDIT_B).
- In IDLE, A and B hold and all buttons are ignored.

Operand update (one step):
- inc: nibble <= nibble+1 mod 16 (F->0). No carry into the neighbouring nibble.
- dec: nibble <= nibble-1 mod 16 (0->F). No borrow.
- inc and dec pulses in the same cycle: nibble <= 0 (clear).
- Only the target nibble changes; the other 60 bits and the non-selected operand hold.
- Latency: a pulse sampled at edge k is visible on A/B at edge k+1 (one register stage).

Cursor:
- left: cursor+1 mod 4 (3 wraps to 0). right: cursor-1 mod 4 (0 wraps to 3).
- left and right together: no move.
- Cursor moves and nibble edits in the same cycle are both applied. The edit uses the pre-move cursor.
- A change of digit_grp does not reset the cursor.

Auto-repeat (independent for inc and dec):
- Counter counts while btn_level[i]==1 and the state is EDIT_*.
- After REPEAT_DLY cycles of hold: one extra step, then repeating flag set.
- While repeating: one step every REPEAT_PER cycles.
- Release clears counter and flag.
- Repeat steps follow the same rules as pulses. If inc and dec repeat steps coincide, the result is a clear.
- A repeat step coinciding with a btn_pulse of the same button counts once.

blink:
- In EDIT_*: blink = 4'b0001 << cursor.
- In IDLE: blink = 0.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=0, ST_EDIT_A=1, ST_EDIT_B=2.
  - button index constants BTN_INC=0, BTN_DEC=1, BTN_LEFT=2, BTN_RIGHT=3.
  - default REPEAT_DLY and REPEAT_PER values.
- One sub-module, btn_repeat:
  - inputs: clk, rst, enable, level, pulse.
  - output: step.
  - contains the hold counter and repeating flag.
  - instantiated twice (inc, dec).
- Nibble read-modify-write and the FSM stay in operand_entry.

Test Plan:
1. Reset mid-edit: disp_sel=0 with A=0x...0000_00A5, assert rst. A=0, B=0, state=0, blink=0 asynchronously, before the next clk edge.
2. Wrap and latency:
   - Stimulus: disp_sel=0, digit_grp=0, cursor=0, A=0; one dec pulse, then two inc pulses.
   - Required: A=0x000F one cycle after the dec pulse; A=0x0000 after the first inc; A=0x0001 after the second inc. A[63:4] never changes.
3. Window and cursor:
   - Stimulus: disp_sel=1, digit_grp=3, three left pulses, then one inc pulse.
   - Required: cursor=3, blink=4'b1000, B=0x1000_0000_0000_0000. A is unchanged.
4. Simultaneous events:
   - Stimulus: nibble=7, inc and dec pulses in the same cycle → nibble=0.
   - Stimulus: left and right pulses in the same cycle → cursor unchanged.
   - Stimulus: disp_sel changes 0->1 in the same cycle as an inc pulse → A and B unchanged, cursor=0, state=2.
5. Auto-repeat (REPEAT_DLY=10, REPEAT_PER=3):
   - Stimulus: hold btn_level[0] for 20 cycles from nibble=0, with an inc pulse on the first cycle.
   - Required: nibble=1 after the pulse, 2 at hold cycle 10, then +1 every 3 cycles, giving nibble=5 at cycle 20.
   - Release stops further increments.
6. IDLE lock: disp_sel=5, all buttons pulsed and held for 50 cycles. A and B unchanged, blink=0, state=0.
